instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcode constants, the NOP encoding,
// the default boot address, the fetch FSM states and the fetch buffer entry.
package riscv_pkg;

    localparam logic [6:0] I_Type  = 7'b0010011;
    localparam logic [6:0] U_Type  = 7'b0110111;
    localparam logic [6:0] B_Type  = 7'b1100011;
    localparam logic [6:0] S_Type  = 7'b0100011;
    localparam logic [6:0] J_Type  = 7'b1101111;
    localparam logic [6:0] JR_Type = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetches are always word aligned, so the two low bits of a target are dropped
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer of fetched {pc, instr} pairs between instruction
// memory and decode. Clear wins over push/pop; push and pop may coincide.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     pushData_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify push/pop so the buffer never overflows or underflows
    always_comb begin
        doPop  = pop_i && (count_q != '0);
        doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (doPush && !clear_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, tracks
// in-flight requests, buffers returned words with their PC and hands them to
// decode. A redirect flushes the buffer and drops responses still in flight.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] Instruction_bus_o,
    output logic [6:0]  op_o,
    output logic [31:0] pc_o
);

    localparam int           CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e     state_q;
    logic             imemReq_q;
    logic [31:0]      imemAddr_q, imemAddr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      lastPc_q;

    logic             reqAccepted;
    logic             rspAccepted;
    logic             rspDropped;
    logic             fifoPush;
    logic             fifoPop;
    logic             fifoEmpty;
    logic             roomNext;
    logic [CNT_W-1:0] fifoCount;
    logic [CNT_W-1:0] fifoCountNext;
    logic [31:0]      pushPc;
    fetch_entry_t     fifoWrData;
    fetch_entry_t     fifoHead;

    // Per-cycle request/response bookkeeping, next fetch address and buffer control
    always_comb begin
        reqAccepted   = imemReq_q && imem_gnt_i;
        rspAccepted   = imem_rvalid_i && (outstanding_q != '0);
        rspDropped    = rspAccepted && ((discard_q != '0) || redirect_i);
        fifoPush      = rspAccepted && !rspDropped;
        fifoPop       = !fifoEmpty && dec_ready_i && !redirect_i;

        outstanding_d = outstanding_q + CNT_W'(reqAccepted) - CNT_W'(rspAccepted);

        discard_d = discard_q;
        if (rspAccepted && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
        if (redirect_i && (state_q != FLUSH)) begin
            discard_d = outstanding_d;
        end

        imemAddr_d = imemAddr_q;
        if (redirect_i) begin
            imemAddr_d = alignPc(redirect_pc_i);
        end else if (reqAccepted) begin
            imemAddr_d = imemAddr_q + 32'd4;
        end

        fifoCountNext = redirect_i ? '0 : fifoCount + CNT_W'(fifoPush) - CNT_W'(fifoPop);
        roomNext      = ({1'b0, outstanding_d} + {1'b0, fifoCountNext}) < DEPTH_C;

        // Outside a flush all in-flight requests are consecutive words ending
        // just below the current fetch address, so the oldest one's PC follows
        pushPc = imemAddr_q - (32'(outstanding_q) << 2);

        fifoWrData = '{pc: pushPc, instr: imem_rdata_i};
    end

    // Fetch FSM with registered request, address, counters and last shown PC
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BOOT;
            imemReq_q     <= 1'b0;
            imemAddr_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            lastPc_q      <= '0;
        end else begin
            imemAddr_q    <= imemAddr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (!fifoEmpty) begin
                lastPc_q <= fifoHead.pc;
            end
            case (state_q)
                BOOT: begin
                    state_q   <= FETCH;
                    imemReq_q <= roomNext;
                end
                FETCH: begin
                    if (redirect_i && (discard_d != '0)) begin
                        state_q   <= FLUSH;
                        imemReq_q <= 1'b0;
                    end else begin
                        state_q   <= FETCH;
                        imemReq_q <= roomNext;
                    end
                end
                FLUSH: begin
                    if (discard_d == '0) begin
                        state_q   <= FETCH;
                        imemReq_q <= roomNext;
                    end else begin
                        state_q   <= FLUSH;
                        imemReq_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= BOOT;
                    imemReq_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (redirect_i),
        .push_i     (fifoPush),
        .pushData_i (fifoWrData),
        .pop_i      (fifoPop),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount),
        .head_o     (fifoHead)
    );

    assign imem_req_o        = imemReq_q;
    assign imem_addr_o       = imemAddr_q;
    assign dec_valid_o       = !fifoEmpty;
    assign Instruction_bus_o = fifoEmpty ? NOP_INSTR : fifoHead.instr;
    assign op_o              = Instruction_bus_o[6:0];
    assign pc_o              = fifoEmpty ? lastPc_q : fifoHead.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed cycle vectors, a
// request/response level model of the fetch unit, and literal spot checks.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] BOOT_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] Instruction_bus_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;

    int checksTotal  = 0;
    int checksPassed = 0;
    int grantCount   = 0;

    instruction_fetch_unit #(
        .RESET_PC   (BOOT_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_gnt_i        (imem_gnt_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .dec_valid_o       (dec_valid_o),
        .dec_ready_i       (dec_ready_i),
        .Instruction_bus_o (Instruction_bus_o),
        .op_o              (op_o),
        .pc_o              (pc_o)
    );

    always #5 clk = ~clk;

    // Instruction memory contents seen by the responder
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr << 5) ^ 32'h1234_5677;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        bit          drop;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    pend_t       pendQ[$];
    entry_t      bufQ[$];
    logic [31:0] mAddr;
    logic [31:0] mLastPc;
    bit          mBoot;
    bit          modelValid = 1'b0;

    // Memory-side queue of granted addresses awaiting a response
    logic [31:0] rspQ[$];

    function automatic bit mFlushing();
        foreach (pendQ[i]) begin
            if (pendQ[i].drop) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit mReq();
        return !mBoot && !mFlushing() && ((pendQ.size() + bufQ.size()) < DEPTH);
    endfunction

    bit          mGranted;
    bit          mPopNow;
    bit          mPushNow;
    pend_t       mRsp;
    entry_t      mNew;
    logic [31:0] mShownPc;

    // Advance the model by one clock using the inputs applied this cycle
    always @(posedge clk) begin
        if (!reset) begin
            pendQ.delete();
            bufQ.delete();
            mAddr   = BOOT_PC;
            mLastPc = 32'h0;
            mBoot   = 1'b1;
        end else begin
            mGranted = mReq() && imem_gnt_i;
            mShownPc = (bufQ.size() > 0) ? bufQ[0].pc : mLastPc;
            mPopNow  = (bufQ.size() > 0) && dec_ready_i && !redirect_i;
            mPushNow = 1'b0;
            if (imem_rvalid_i && (pendQ.size() > 0)) begin
                mRsp = pendQ.pop_front();
                if (!mRsp.drop && !redirect_i) begin
                    mPushNow    = 1'b1;
                    mNew.pc     = mRsp.pc;
                    mNew.instr  = imem_rdata_i;
                end
            end
            mLastPc = mShownPc;
            if (mPopNow) void'(bufQ.pop_front());
            if (mPushNow) bufQ.push_back(mNew);
            if (mGranted) pendQ.push_back('{mAddr, redirect_i});
            if (redirect_i) begin
                foreach (pendQ[i]) pendQ[i].drop = 1'b1;
                bufQ.delete();
                mAddr = redirect_pc_i & 32'hFFFF_FFFC;
            end else if (mGranted) begin
                mAddr = mAddr + 32'd4;
            end
            mBoot = 1'b0;
        end
        modelValid = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    logic [31:0] expInstr;
    logic [31:0] expPc;

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (modelValid) begin
            expInstr = (bufQ.size() > 0) ? bufQ[0].instr : NOP;
            expPc    = (bufQ.size() > 0) ? bufQ[0].pc : mLastPc;
            checkOutput("imem_req_o", 32'(imem_req_o), 32'(mReq()));
            checkOutput("imem_addr_o", imem_addr_o, mAddr);
            checkOutput("dec_valid_o", 32'(dec_valid_o), 32'(bufQ.size() > 0));
            checkOutput("Instruction_bus_o", Instruction_bus_o, expInstr);
            checkOutput("op_o", 32'(op_o), 32'(expInstr[6:0]));
            checkOutput("pc_o", pc_o, expPc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit rst, input bit gnt, input bit rspEn, input bit rdy,
                                 input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        reset         = rst;
        imem_gnt_i    = gnt;
        dec_ready_i   = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (rspEn && (rspQ.size() > 0)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memWord(rspQ.pop_front());
        end
        if (rst && imem_req_o && gnt) begin
            rspQ.push_back(imem_addr_o);
            grantCount++;
        end
    endtask

    task automatic step(input bit gnt, input bit rspEn, input bit rdy,
                        input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        applyStimulus(1'b1, gnt, rspEn, rdy, redir, rpc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        reset         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        dec_ready_i   = 1'b0;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // BOOT cycle right after release: reset values still visible
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("boot_req", 32'(imem_req_o), 32'h0);
        checkOutput("boot_addr", imem_addr_o, 32'h0040_0000);
        checkOutput("boot_dec_valid", 32'(dec_valid_o), 32'h0);
        checkOutput("boot_instr", Instruction_bus_o, 32'h0000_0013);
        checkOutput("boot_op", 32'(op_o), 32'h13);
        checkOutput("boot_pc", pc_o, 32'h0);
        grantCount = 0;

        // Streaming fetch with decode stalled
        step(1, 1, 0);
        checkOutput("first_addr", imem_addr_o, 32'h0040_0000);
        checkOutput("first_req", 32'(imem_req_o), 32'h1);
        step(1, 1, 0);
        checkOutput("second_addr", imem_addr_o, 32'h0040_0004);
        checkOutput("valid_after_1", 32'(dec_valid_o), 32'h0);
        step(1, 1, 0);
        checkOutput("valid_after_2", 32'(dec_valid_o), 32'h1);
        checkOutput("req_full", 32'(imem_req_o), 32'h0);
        step(1, 1, 0);
        checkOutput("head_pc0", pc_o, 32'h0040_0000);
        step(1, 1, 0);
        checkOutput("req_stalled", 32'(imem_req_o), 32'h0);
        checkOutput("stalled_grants", 32'(grantCount), 32'd2);

        // Decode drains in order
        step(0, 0, 1);
        step(0, 0, 1);
        checkOutput("head_pc1", pc_o, 32'h0040_0004);
        step(1, 0, 0);
        checkOutput("empty_valid", 32'(dec_valid_o), 32'h0);
        checkOutput("empty_pc_hold", pc_o, 32'h0040_0004);
        checkOutput("empty_nop", Instruction_bus_o, 32'h0000_0013);

        // Redirect with two requests in flight
        step(1, 0, 0);
        step(0, 0, 0, 1'b1, 32'h0040_0102);
        step(1, 1, 0);
        checkOutput("flush_req", 32'(imem_req_o), 32'h0);
        checkOutput("flush_addr", imem_addr_o, 32'h0040_0100);
        checkOutput("flush_valid", 32'(dec_valid_o), 32'h0);
        step(1, 1, 0);
        checkOutput("flush_req2", 32'(imem_req_o), 32'h0);
        checkOutput("flush_valid2", 32'(dec_valid_o), 32'h0);
        step(1, 0, 0);
        checkOutput("refetch_req", 32'(imem_req_o), 32'h1);
        checkOutput("refetch_addr", imem_addr_o, 32'h0040_0100);
        checkOutput("refetch_valid", 32'(dec_valid_o), 32'h0);
        step(0, 1, 0);
        step(1, 0, 0);
        checkOutput("target_valid", 32'(dec_valid_o), 32'h1);
        checkOutput("target_pc", pc_o, 32'h0040_0100);
        checkOutput("target_instr", Instruction_bus_o, 32'h1A34_7677);

        // Redirect coinciding with a response and a decode pop
        step(0, 1, 1, 1'b1, 32'h0040_0200);
        step(0, 0, 0);
        checkOutput("coll_valid", 32'(dec_valid_o), 32'h0);
        checkOutput("coll_pc_hold", pc_o, 32'h0040_0100);
        checkOutput("coll_addr", imem_addr_o, 32'h0040_0200);

        // Grant withheld: request and address hold
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            checkOutput("hold_req", 32'(imem_req_o), 32'h1);
            checkOutput("hold_addr", imem_addr_o, 32'h0040_0200);
        end

        // Address wrap at the top of memory
        step(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        step(1, 0, 0);
        checkOutput("top_addr", imem_addr_o, 32'hFFFF_FFFC);
        step(0, 1, 0);
        checkOutput("wrap_addr", imem_addr_o, 32'h0000_0000);
        step(0, 0, 1);
        checkOutput("wrap_valid", 32'(dec_valid_o), 32'h1);
        checkOutput("wrap_pc", pc_o, 32'hFFFF_FFFC);

        // Second redirect while flushing keeps the discard count
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0, 1'b1, 32'h0060_0000);
        step(0, 1, 0, 1'b1, 32'h0050_0000);
        step(0, 0, 0);
        checkOutput("reflush_req", 32'(imem_req_o), 32'h0);
        checkOutput("reflush_addr", imem_addr_o, 32'h0050_0000);
        step(0, 1, 0);
        step(0, 0, 0);
        checkOutput("reflush_done_req", 32'(imem_req_o), 32'h1);
        checkOutput("reflush_done_addr", imem_addr_o, 32'h0050_0000);

        // Reset while requests are in flight; late responses are ignored
        step(1, 0, 0);
        step(1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_req", 32'(imem_req_o), 32'h0);
        checkOutput("rst_addr", imem_addr_o, 32'h0040_0000);
        step(0, 1, 0);
        checkOutput("rst_fetch_req", 32'(imem_req_o), 32'h1);
        step(0, 0, 0);
        checkOutput("rst_stale_valid", 32'(dec_valid_o), 32'h0);

        // Mixed traffic: overlapping push/pop, stalls and one redirect
        for (int i = 0; i < 24; i++) begin
            step((i % 3) != 0, (i % 2) == 1, (i % 4) != 1, i == 13, 32'h0070_0008);
        end
        repeat (6) step(0, 1, 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
